// File: rtl/debounce_pkg.sv
// debounce_pkg: shared state encoding and counter-width helper for the debouncer slice
package debounce_pkg;

    typedef enum logic [1:0] {
        S_LOW       = 2'd0,
        S_WAIT_HIGH = 2'd1,
        S_HIGH      = 2'd2,
        S_WAIT_LOW  = 2'd3
    } state_t;

    function automatic int cnt_width(input int cycles);
        return $clog2(cycles);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one-input debounce FSM with qualification counter, registered level and edge strobes; DEBOUNCE_SYNC_EN adds a 2-flop input synchronizer
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic noisy,
    output logic debounced,
    output logic rise_pulse,
    output logic fall_pulse
);
    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             in_bit, deb_nxt, rise_nxt, fall_nxt;

`ifdef DEBOUNCE_SYNC_EN
    logic [1:0] sync_q;
    // two-flop synchronizer in front of the FSM, cleared by reset
    always_ff @(posedge clk) begin
        sync_q <= reset_n ? {sync_q[0], noisy} : 2'b00;
    end
    assign in_bit = sync_q[1];
`else
    assign in_bit = noisy;
`endif

    // state, counter and registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= S_LOW;
            cnt        <= '0;
            debounced  <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            debounced  <= deb_nxt;
            rise_pulse <= rise_nxt;
            fall_pulse <= fall_nxt;
        end
    end

    // next state: any disagreeing sample in a wait state abandons qualification
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_LOW: begin
                if (in_bit) begin
                    state_nxt = S_WAIT_HIGH;
                    cnt_nxt   = '0;
                end
            end
            S_WAIT_HIGH: begin
                if (!in_bit) state_nxt = S_LOW;
                else if (cnt == CNT_MAX) state_nxt = S_HIGH;
                else cnt_nxt = cnt + 1'b1;
            end
            S_HIGH: begin
                if (!in_bit) begin
                    state_nxt = S_WAIT_LOW;
                    cnt_nxt   = '0;
                end
            end
            S_WAIT_LOW: begin
                if (in_bit) state_nxt = S_HIGH;
                else if (cnt == CNT_MAX) state_nxt = S_LOW;
                else cnt_nxt = cnt + 1'b1;
            end
        endcase
    end

    // output values for the next cycle; strobes only on a completed qualification
    always_comb begin
        deb_nxt  = (state_nxt == S_HIGH) || (state_nxt == S_WAIT_LOW);
        rise_nxt = (state == S_WAIT_HIGH) && (state_nxt == S_HIGH);
        fall_nxt = (state == S_WAIT_LOW) && (state_nxt == S_LOW);
    end

endmodule

// File: rtl/debouncer_multi.sv
// debouncer_multi: N_CH independent debounce channels with level and press/release strobes; DEBOUNCE_SYNC_EN enables input synchronizers
module debouncer_multi
    import debounce_pkg::*;
#(
    parameter int N_CH            = 4,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N_CH-1:0] noisy,
    output logic [N_CH-1:0] debounced,
    output logic [N_CH-1:0] rise_pulse,
    output logic [N_CH-1:0] fall_pulse
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk       (clk),
            .reset_n   (reset_n),
            .noisy     (noisy[i]),
            .debounced (debounced[i]),
            .rise_pulse(rise_pulse[i]),
            .fall_pulse(fall_pulse[i])
        );
    end

endmodule

// File: tb/tb_debouncer_multi.sv
// tb_debouncer_multi: directed scoreboard bench for debouncer_multi (N_CH=4, DEBOUNCE_CYCLES=4), DEBOUNCE_SYNC_EN selects the synchronized sequence
module tb_debouncer_multi;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] noisy = 4'h0;
    logic [3:0] debounced, rise_pulse, fall_pulse;
    logic [11:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int pops = 0;

    debouncer_multi #(
        .N_CH(4),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .noisy     (noisy),
        .debounced (debounced),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse)
    );

    always #5 clk = ~clk;

    // exp packs {debounced, rise_pulse, fall_pulse} as three hex digits, valid after the edge
    task automatic step(input logic rn, input logic [3:0] nz, input logic [11:0] exp, input int n);
        for (int k = 0; k < n; k++) begin
            reset_n = rn;
            noisy   = nz;
            @(posedge clk);
            exp_q.push_back(exp);
            #1;
        end
    endtask

    initial begin
        logic [11:0] e, got;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {debounced, rise_pulse, fall_pulse};
                checks++;
                pops++;
                if (got !== e)
                    begin
                        errors++;
                        $display("FAIL cycle%0d deb/rise/fall got %h want %h", pops, got, e);
                    end
            end
        end
    end

    initial begin
`ifdef DEBOUNCE_SYNC_EN
        step(0, 4'hF, 12'h000, 3);
        step(1, 4'h0, 12'h000, 2);
        step(1, 4'h1, 12'h000, 6);
        step(1, 4'h1, 12'h110, 1);
        step(1, 4'h1, 12'h100, 1);
        step(1, 4'h0, 12'h100, 6);
        step(1, 4'h0, 12'h001, 1);
        step(1, 4'h0, 12'h000, 1);
`else
        step(0, 4'hF, 12'h000, 3);
        step(1, 4'hF, 12'h000, 4);
        step(1, 4'hF, 12'hFF0, 1);
        step(1, 4'hF, 12'hF00, 1);
        step(0, 4'h0, 12'h000, 1);
        step(1, 4'h1, 12'h000, 4);
        step(1, 4'h1, 12'h110, 1);
        step(1, 4'h1, 12'h100, 2);
        step(1, 4'h3, 12'h100, 3);
        step(1, 4'h1, 12'h100, 1);
        step(1, 4'h3, 12'h100, 3);
        step(1, 4'h1, 12'h100, 1);
        step(1, 4'h5, 12'h100, 4);
        step(1, 4'h5, 12'h540, 1);
        step(1, 4'h1, 12'h500, 2);
        step(1, 4'h5, 12'h500, 1);
        step(1, 4'h1, 12'h500, 4);
        step(1, 4'h1, 12'h104, 1);
        step(1, 4'h1, 12'h100, 1);
        step(1, 4'h0, 12'h100, 4);
        step(1, 4'h0, 12'h001, 1);
        step(1, 4'hF, 12'h000, 4);
        step(1, 4'hF, 12'hFF0, 1);
        step(1, 4'hF, 12'hF00, 1);
        step(1, 4'h0, 12'hF00, 2);
        step(0, 4'h0, 12'h000, 1);
        step(1, 4'h0, 12'h000, 3);
        step(1, 4'hF, 12'h000, 2);
        step(0, 4'hF, 12'h000, 1);
        step(1, 4'h0, 12'h000, 2);
`endif
        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/debouncer_multi.md
Name: debouncer_multi

Overview:
- Parametrised successor to the single-button delayed debouncer.
- Debounces N_CH independent asynchronous button/switch inputs.
- Each channel has its own internal qualification counter; no external timer handshake.
- Emits per-channel stable levels plus single-cycle press/release strobes for downstream control logic (LED/UI FSMs, counters).

Parameters:
- N_CH, 4, number of independent input channels (>=1).
- DEBOUNCE_CYCLES, 1000000, consecutive clk cycles an input must hold a new level before it is accepted (>=2).
- CNT_W, $clog2(DEBOUNCE_CYCLES), localparam: width of each channel counter; not overridable.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  synchronous, active-low reset, sampled on rising clk.
- noisy  input  N_CH  raw bouncing inputs, bit i = channel i.
- debounced  output  N_CH  registered, qualified level per channel.
- rise_pulse  output  N_CH  one-cycle strobe when debounced[i] goes 0->1.
- fall_pulse  output  N_CH  one-cycle strobe when debounced[i] goes 1->0.

Behaviour:
- Reset
  - reset_n=0 at a rising edge: every channel goes to S_LOW with cnt=0.
  - debounced, rise_pulse and fall_pulse are all 0.
  - Reset mid-qualification discards progress; no strobe is emitted.
- Per-channel FSM: four states; channels are fully independent; "in" = sampled input bit.
  - S_LOW: in=1 -> S_WAIT_HIGH, cnt<=0; else stay.
  - S_WAIT_HIGH: in=0 -> S_LOW (bounce rejected). Else if cnt==DEBOUNCE_CYCLES-1 -> S_HIGH. Else cnt<=cnt+1.
  - S_HIGH: in=0 -> S_WAIT_LOW, cnt<=0; else stay.
  - S_WAIT_LOW: in=1 -> S_HIGH. Else if cnt==DEBOUNCE_CYCLES-1 -> S_LOW. Else cnt<=cnt+1.
- Outputs
  - debounced[i] is a register: 1 in S_HIGH/S_WAIT_LOW, 0 in S_LOW/S_WAIT_HIGH. It never glitches or holds X.
  - rise_pulse[i] is registered, high exactly one cycle, on the edge entering S_HIGH from S_WAIT_HIGH.
  - fall_pulse[i] follows the same rule, entering S_LOW from S_WAIT_LOW.
  - Returning S_WAIT_LOW->S_HIGH or S_WAIT_HIGH->S_LOW produces no strobe.
- Latency: input stable from first sampling edge E0 -> debounced and strobe assert after edge E0+DEBOUNCE_CYCLES (DEBOUNCE_CYCLES+1 edges).
- Counter: cnt never exceeds DEBOUNCE_CYCLES-1; no wrap-around is possible. cnt holds its value in the stable states.
- A single-cycle bounce in a WAIT state restarts qualification completely.
- Several channels qualifying on the same cycle assert strobes simultaneously; there is no arbitration.

Optional Feature:
- Macro: DEBOUNCE_SYNC_EN.
- Defined:
  - Each noisy bit passes through a 2-flop synchronizer before the FSM.
  - Synchronizer flops reset to 0 under reset_n.
  - All latencies increase by exactly 2 cycles.
- Undefined:
  - The FSM samples noisy directly.
  - The integrator guarantees noisy is already synchronous to clk.

Decomposition:
- Shared package debounce_pkg holds:
  - state typedef: 2-bit enum S_LOW=0, S_WAIT_HIGH=1, S_HIGH=2, S_WAIT_LOW=3.
  - function computing CNT_W.
- Sub-module debounce_channel:
  - contains one FSM, its counter, the optional synchronizer and the three output registers.
  - instantiated N_CH times in a generate loop.

Test Plan (bench uses N_CH=4, DEBOUNCE_CYCLES=4, macro undefined unless stated):
- Reset: hold reset_n=0 for 3 cycles with noisy=4'hF -> all outputs 0; after release, debounced=4'hF only after 5 edges.
- Clean press: noisy[0] 0->1 and held -> debounced[0]=1 and rise_pulse[0]=1 for exactly one cycle, 5 edges after first sample; other bits stay 0.
- Bounce rejection: noisy[1] toggles 1,1,1,0,1,1,1,0 -> debounced[1] stays 0, no rise_pulse[1].
- Release with glitch: channel 2 high; noisy[2]=0 for 2 cycles, then 1 -> no fall_pulse. Then 0 held -> fall_pulse[2] after 5 edges.
- Simultaneous channels: noisy 4'h0->4'hF on one edge -> rise_pulse=4'hF on a single cycle. Mid-qualification reset -> no strobes, debounced=0.
- DEBOUNCE_SYNC_EN defined: clean-press scenario -> debounced[0] asserts after 7 edges.
